// File: rtl/image_loader.sv
// image_loader: gathers the bytes of one packed binary image from the UART,
// unpacks them LSB-first into a 1-bit pixel memory and pulses ready when the
// image is complete. A one-entry holding buffer absorbs a byte that arrives
// while the previous one is still being unpacked.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | nothing to unpack, hold empty, waiting for rx_rdy
// UNPACK | one pixel written per cycle from shift[0], bit_cnt 0..7
module image_loader #(
    parameter int NUM_BYTES = 98,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              q,
    output logic              ready,
    output logic              busy,
    output logic              overrun
);

    localparam int PIXELS = NUM_BYTES * 8;
    // Pixel address is {byte_cnt, bit_cnt}, so the byte counter takes the
    // upper address bits.
    localparam int BYTE_W = ADDR_W - 3;
    localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(NUM_BYTES - 1);
    localparam logic [ADDR_W-1:0] PIXELS_LIM = ADDR_W'(PIXELS);

    typedef enum logic {
        IDLE   = 1'b0,
        UNPACK = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        shift, shift_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic [BYTE_W-1:0] byte_cnt, byte_cnt_nxt;
    logic [7:0]        hold, hold_nxt;
    logic              hold_valid, hold_valid_nxt;
    logic              ready_nxt;
    logic              overrun_nxt;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    logic mem [0:PIXELS-1];

    assign wr_addr = {byte_cnt, bit_cnt};
    assign busy    = (state == UNPACK) | hold_valid;

    // State register and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_cnt   <= '0;
            hold       <= 8'h00;
            hold_valid <= 1'b0;
            ready      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift      <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            byte_cnt   <= byte_cnt_nxt;
            hold       <= hold_nxt;
            hold_valid <= hold_valid_nxt;
            ready      <= ready_nxt;
            overrun    <= overrun_nxt;
        end
    end

    // Next-state, holding-buffer and byte-counter logic.
    always_comb begin
        state_nxt      = state;
        shift_nxt      = shift;
        bit_cnt_nxt    = bit_cnt;
        byte_cnt_nxt   = byte_cnt;
        hold_nxt       = hold;
        hold_valid_nxt = hold_valid;
        ready_nxt      = 1'b0;
        overrun_nxt    = overrun;
        wr_en          = 1'b0;

        case (state)
            IDLE: begin
                if (rx_rdy) begin
                    shift_nxt   = rx_data;
                    bit_cnt_nxt = 3'd0;
                    state_nxt   = UNPACK;
                end
            end

            UNPACK: begin
                wr_en       = 1'b1;
                shift_nxt   = {1'b0, shift[7:1]};
                bit_cnt_nxt = bit_cnt + 3'd1;

                if (bit_cnt == 3'd7) begin
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt_nxt = '0;
                        ready_nxt    = 1'b1;
                    end else begin
                        byte_cnt_nxt = byte_cnt + BYTE_W'(1);
                    end

                    // Drain the hold first; a byte arriving on this same
                    // cycle takes its place so nothing is lost.
                    if (hold_valid) begin
                        shift_nxt = hold;
                        if (rx_rdy) begin
                            hold_nxt = rx_data;
                        end else begin
                            hold_valid_nxt = 1'b0;
                        end
                    end else if (rx_rdy) begin
                        shift_nxt = rx_data;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (rx_rdy) begin
                    if (!hold_valid) begin
                        hold_nxt       = rx_data;
                        hold_valid_nxt = 1'b1;
                    end else begin
                        overrun_nxt = 1'b1;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Pixel memory write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= shift[0];
        end
    end

    // Registered read port; out-of-range addresses read as 0 and a same-cycle
    // write is not forwarded, so the old pixel is returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (rd_addr < PIXELS_LIM) begin
            q <= mem[rd_addr];
        end else begin
            q <= 1'b0;
        end
    end

endmodule
